// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// dmem_arb_pkg : shared types and widths for the data-memory arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 9;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CPU_RD = 2'd1,
        OWN_EXT_RD = 2'd2
    } owner_e;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_sel.sv
// ============================================================================
// dmem_arb_sel : grant decision between the CPU and the external port.
//                DMEM_ARB_RR_EN selects strict round-robin, else CPU priority
//                with a starvation bound.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dmem_arb_sel #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic ext_req,
    output logic cpu_gnt,
    output logic ext_gnt
);

    logic ext_win;

`ifdef DMEM_ARB_RR_EN
    // ext_turn_q set means the external port owns the next contested cycle
    logic ext_turn_q;
    logic ext_turn_d;

    always_comb begin
        ext_win    = ext_req && (!cpu_req || ext_turn_q);
        ext_turn_d = ext_turn_q;
        if (!reset && cpu_req && ext_req) begin
            ext_turn_d = !ext_turn_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_turn_q <= 1'b0;
        end else begin
            ext_turn_q <= ext_turn_d;
        end
    end
`else
    localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    always_comb begin
        ext_win      = ext_req && (!cpu_req || (starve_cnt_q == CNT_MAX));
        starve_cnt_d = '0;
        if (!reset && ext_req && !ext_win) begin
            starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    assign ext_gnt = !reset && ext_win;
    assign cpu_gnt = !reset && cpu_req && !ext_win;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : shares a single-port sync-read data memory between the CPU
//                and a read-only external port (optional DMEM_ARB_RR_EN).
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic [ADDR_W-1:0] ext_addr,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_e            owner_q;
    owner_e            owner_d;
    logic [DATA_W-1:0] ext_last_q;
    logic [DATA_W-1:0] ext_last_d;

    dmem_arb_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .clk     (clk),
        .reset   (reset),
        .cpu_req (cpu_req),
        .ext_req (ext_req),
        .cpu_gnt (cpu_gnt),
        .ext_gnt (ext_gnt)
    );

    always_comb begin
        mem_en    = cpu_gnt | ext_gnt;
        mem_we    = cpu_gnt & cpu_we;
        mem_wdata = cpu_wdata;
        mem_addr  = '0;
        if (cpu_gnt) begin
            mem_addr = cpu_addr;
        end else if (ext_gnt) begin
            mem_addr = ext_addr;
        end

        // Owner records who issued this cycle's read so next cycle's data is steered
        owner_d = OWN_NONE;
        if (cpu_gnt && !cpu_we) begin
            owner_d = OWN_CPU_RD;
        end else if (ext_gnt) begin
            owner_d = OWN_EXT_RD;
        end

        cpu_rvalid = (owner_q == OWN_CPU_RD);
        ext_rvalid = (owner_q == OWN_EXT_RD);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        ext_rdata  = ext_rvalid ? mem_rdata : ext_last_q;
        ext_last_d = ext_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= OWN_NONE;
            ext_last_q <= '0;
        end else begin
            owner_q    <= owner_d;
            ext_last_q <= ext_last_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : directed and randomized bench for dmem_arbiter with a
//                   transaction-level reference model and a memory model.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_we  = 1'b0;
    logic [AW-1:0] cpu_addr  = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ext_req = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic          ext_gnt, ext_rvalid;
    logic [DW-1:0] ext_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ext_req    (ext_req),
        .ext_addr   (ext_addr),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [DW-1:0] init_word(int a);
        return (a == 64) ? 32'hDEADBEEF : 32'h1000_0000 + a * 32'h0001_0003;
    endfunction

    // Synchronous-read memory attached to the arbiter
    logic [DW-1:0] mem [512];
    bit            mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    assert property (@(posedge clk) disable iff (reset) (cpu_req && !cpu_gnt) |=> cpu_req)
        else $error("FAIL cpu_req dropped before grant");
    assert property (@(posedge clk) disable iff (reset) (ext_req && !ext_gnt) |=> ext_req)
        else $error("FAIL ext_req dropped before grant");

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0] shadow [512];
    int            m_loss;
    bit            m_rr_ext;
    bit            m_cpu_rv, m_ext_rv;
    logic [DW-1:0] m_cpu_data, m_ext_data, m_ext_last;
    bit            lg_cpu, lg_ext;
    logic          d_cpu_gnt, d_ext_gnt, d_cpu_rvalid, d_ext_rvalid, d_mem_we;
    logic [DW-1:0] d_ext_rdata;

    task automatic reset_model();
        m_loss = 0; m_rr_ext = 1'b0; m_cpu_rv = 1'b0; m_ext_rv = 1'b0;
        m_cpu_data = '0; m_ext_data = '0; m_ext_last = '0;
    endtask

    task automatic cycle();
        bit            e_cpu, e_ext;
        logic [AW-1:0] e_addr;
        @(negedge clk);
        if (reset) begin
            reset_model();
            e_cpu = 1'b0;
            e_ext = 1'b0;
        end else begin
`ifdef DMEM_ARB_RR_EN
            e_ext = ext_req && (!cpu_req || m_rr_ext);
`else
            e_ext = ext_req && (!cpu_req || m_loss == SM);
`endif
            e_cpu = cpu_req && !e_ext;
        end
        e_addr = e_cpu ? cpu_addr : (e_ext ? ext_addr : '0);

        d_cpu_gnt = cpu_gnt; d_ext_gnt = ext_gnt; d_cpu_rvalid = cpu_rvalid;
        d_ext_rvalid = ext_rvalid; d_ext_rdata = ext_rdata; d_mem_we = mem_we;

        check("cpu_gnt",    32'(cpu_gnt),    32'(e_cpu));
        check("ext_gnt",    32'(ext_gnt),    32'(e_ext));
        check("mem_en",     32'(mem_en),     32'(e_cpu | e_ext));
        check("mem_we",     32'(mem_we),     32'(e_cpu & cpu_we));
        check("mem_addr",   32'(mem_addr),   32'(e_addr));
        check("mem_wdata",  mem_wdata,       cpu_wdata);
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cpu_rv));
        check("ext_rvalid", 32'(ext_rvalid), 32'(m_ext_rv));
        check("cpu_rdata",  cpu_rdata,       m_cpu_rv ? m_cpu_data : 32'h0);
        check("ext_rdata",  ext_rdata,       m_ext_rv ? m_ext_data : m_ext_last);

        if (m_ext_rv) m_ext_last = m_ext_data;
        m_cpu_rv   = e_cpu && !cpu_we;
        m_cpu_data = shadow[cpu_addr];
        m_ext_rv   = e_ext;
        m_ext_data = shadow[ext_addr];
        if (e_cpu && cpu_we) shadow[cpu_addr] = cpu_wdata;
        if (!reset) begin
            if (cpu_req && ext_req) m_rr_ext = !m_rr_ext;
            if (ext_req && !e_ext) m_loss = (m_loss < SM) ? m_loss + 1 : m_loss;
            else                   m_loss = 0;
        end
        lg_cpu = e_cpu;
        lg_ext = e_ext;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        reset_model();
    endtask

    task automatic new_cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) begin
            if (lg_cpu) cpu_req = 1'b0;
            if (lg_ext) ext_req = 1'b0;
            if (!cpu_req && !ext_req) break;
            cycle();
        end
        check("drain_done", 32'({cpu_req, ext_req}), 32'h0);
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int       ncpu;
        bit [5:0] ext_pat, exp_pat;
        for (int i = 0; i < 512; i++) shadow[i] = init_word(i);
        reset_model();
        lg_cpu = 1'b0; lg_ext = 1'b0;

        // Reset held with both requesters active
        new_cpu(1'b0, 9'd3, '0);
        ext_req = 1'b1; ext_addr = 9'd64;
        repeat (3) cycle();
        reset = 1'b0;

        // Starvation bound: CPU held continuously, ext waits at address 64
        ncpu = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (i == 0) check("first_gnt_after_reset", 32'({d_cpu_gnt, d_cpu_rvalid, d_ext_rvalid}), 32'h4);
            if (d_cpu_gnt) ncpu++;
            if (d_ext_gnt) break;
            if (lg_cpu) new_cpu(1'b0, 9'($urandom_range(0, 31)), '0);
        end
`ifdef DMEM_ARB_RR_EN
        check("cpu_wins_before_ext", 32'(ncpu), 32'd1);
`else
        check("cpu_wins_before_ext", 32'(ncpu), 32'(SM));
`endif
        ext_req = 1'b0;
        cycle();
        check("cpu_regranted", 32'(d_cpu_gnt), 32'd1);
        check("ext_rdata_beef", d_ext_rdata, 32'hDEADBEEF);
        cpu_req = 1'b0;
        cycle();
        check("ext_rdata_hold", d_ext_rdata, 32'hDEADBEEF);

        // External read alone
        ext_req = 1'b1; ext_addr = 9'd64;
        cycle();
        check("ext_only_gnt", 32'(d_ext_gnt), 32'd1);
        ext_req = 1'b0;
        cycle();
        check("ext_only_rvalid", 32'(d_ext_rvalid), 32'd1);
        cycle();
        check("ext_only_hold", d_ext_rdata, 32'hDEADBEEF);

        // Write then read-after-write from the external port
        new_cpu(1'b1, 9'd10, 32'h0000000A);
        cycle();
        check("wr_gnt_we", 32'({d_cpu_gnt, d_mem_we}), 32'h3);
        cpu_req = 1'b0;
        ext_req = 1'b1; ext_addr = 9'd10;
        cycle();
        check("raw_ext_gnt", 32'({d_ext_gnt, d_cpu_rvalid}), 32'h2);
        ext_req = 1'b0;
        cycle();
        check("raw_ext_rdata", d_ext_rdata, 32'h0000000A);
        check("wr_no_cpu_rvalid", 32'(d_cpu_rvalid), 32'd0);

        // Both requesters held for six contested cycles, fresh from reset
        pulse_reset();
        new_cpu(1'b0, 9'd1, '0);
        ext_req = 1'b1; ext_addr = 9'd2;
        ext_pat = '0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            ext_pat[i] = d_ext_gnt;
            if (lg_cpu) new_cpu(1'b0, 9'(i + 20), '0);
            if (lg_ext) ext_addr = 9'(i + 40);
        end
`ifdef DMEM_ARB_RR_EN
        exp_pat = 6'b101010;
`else
        exp_pat = 6'b010000;
`endif
        check("contest_pattern", 32'(ext_pat), 32'(exp_pat));
        drain();

        // Reset between a CPU read grant and its data return
        new_cpu(1'b0, 9'd5, '0);
        cycle();
        check("mid_rst_gnt", 32'(d_cpu_gnt), 32'd1);
        cpu_req = 1'b0;
        pulse_reset();
        cycle();
        check("mid_rst_no_rvalid", 32'({d_cpu_rvalid, d_ext_rvalid}), 32'h0);
        check("mid_rst_ext_last", d_ext_rdata, 32'h0);

        // Randomized traffic on a small address window
        for (int n = 0; n < 3000; n++) begin
            if (!cpu_req || lg_cpu) begin
                if ($urandom_range(0, 3) != 0)
                    new_cpu(1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), $urandom);
                else
                    cpu_req = 1'b0;
            end
            if (!ext_req || lg_ext) begin
                ext_req  = 1'($urandom_range(0, 1));
                ext_addr = 9'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 299) == 0) pulse_reset();
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
